// File: rtl/pmem_pkg.sv
// Shared types and constants for the 128-bit physical-memory responder.
package pmem_pkg;

  localparam int PMEM_OFFSET_BITS = 4;
  localparam int PMEM_ADDR_WIDTH  = 16;

  typedef logic [127:0]                 pmem_line_t;
  typedef logic [PMEM_ADDR_WIDTH-1:0]   pmem_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/pmem_array.sv
// Line storage: synchronous write, combinational read, zero-initialised contents.
module pmem_array
  import pmem_pkg::*;
#(
  parameter int DEPTH_LINES = 4096,
  parameter     INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_LINES)-1:0] i_idx,
  input  pmem_line_t                     i_wdata,
  output pmem_line_t                     o_rdata
);

  pmem_line_t r_mem [DEPTH_LINES];

  // Contents start at zero; reset never touches them.
  initial begin
    for (int i = 0; i < DEPTH_LINES; i++) r_mem[i] = '0;
  end

  // Write port commits the supplied line on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency responder for the mp2 line interface, with sticky protocol-error flag.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_LINES = 4096,
  parameter int LATENCY     = 10,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  pmem_line_t            wdata,
  output logic                  resp,
  output pmem_line_t            rdata,
  output logic                  proto_err
);

  localparam int         IDX_W  = $clog2(DEPTH_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_state_e           r_state;
  logic [7:0]            r_cnt;
  logic                  r_isWrite;
  logic                  r_read;
  logic                  r_write;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  pmem_line_t            r_wdata;
  pmem_line_t            r_rdata;
  logic                  r_protoErr;

  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_arrIdx;
  logic                  w_req;
  logic                  w_we;
  logic                  w_changed;
  pmem_line_t            w_arrLine;

  assign w_idx     = address[PMEM_OFFSET_BITS +: IDX_W];
  assign w_req     = read | write;
  // The single array port reads the incoming line only when LATENCY==1 needs it in IDLE.
  assign w_arrIdx  = (r_state == IDLE) ? w_idx : r_idx;
  assign w_we      = (r_state == RESP) && r_isWrite && !rst;
  assign w_changed = (read != r_read) || (write != r_write) ||
                     (address != r_addr) || (wdata != r_wdata);

  pmem_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_idx  (w_arrIdx),
    .i_wdata(r_wdata),
    .o_rdata(w_arrLine)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_isWrite  <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_protoErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_isWrite <= write;
            r_read    <= read;
            r_write   <= write;
            r_idx     <= w_idx;
            r_addr    <= address;
            r_wdata   <= wdata;
            r_cnt     <= LAT_M1;
            if (read && write) r_protoErr <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= RESP;
              if (!write) r_rdata <= w_arrLine;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 8'd1;
          if (w_changed) r_protoErr <= 1'b1;
          if (r_cnt == 8'd1) begin
            r_state <= RESP;
            if (!r_isWrite) r_rdata <= w_arrLine;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp      = (r_state == RESP);
  assign rdata     = r_rdata;
  assign proto_err = r_protoErr;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: random and directed line traffic against a line-array model.
module tb_pmem_responder;

  localparam int LAT   = 10;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         read;
  logic         write;
  logic [15:0]  address;
  logic [127:0] wdata;
  logic         resp;
  logic [127:0] rdata;
  logic         protoErr;

  typedef struct {
    int           respCyc;
    bit           isWrite;
    int           line;
    logic [127:0] data;
  } exp_t;

  exp_t         expQ[$];
  exp_t         monE;
  logic [127:0] model [DEPTH];
  int           cyc    = 0;
  int           errors = 0;
  int           checks = 0;
  bit           expErr;

  pmem_responder #(
    .ADDR_WIDTH (16),
    .DEPTH_LINES(DEPTH),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .address  (address),
    .wdata    (wdata),
    .resp     (resp),
    .rdata    (rdata),
    .proto_err(protoErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive a request; accOff is 1 when issued during the RESP cycle of the previous op.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [127:0] data, input int accOff);
    exp_t e;
    read    = rd;
    write   = wr;
    address = addr;
    wdata   = data;
    e.respCyc = cyc + accOff + LAT;
    e.isWrite = wr;
    e.line    = int'(addr[7:4]);
    e.data    = data;
    expQ.push_back(e);
    if (rd && wr) expErr = 1'b1;
  endtask

  task automatic waitResp(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL respTimeout: got no resp, required one within 200 cycles");
    end
  endtask

  task automatic idleBus();
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic doOp(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] data);
    int c;
    applyStimulus(rd, wr, addr, data, 0);
    waitResp(c);
    idleBus();
    @(negedge clk);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    expQ.delete();
    expErr = 1'b0;
    @(negedge clk);
    checkOutput("rstResp", resp, 1'b0);
    checkOutput("rstProtoErr", protoErr, 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every resp must match the oldest outstanding request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && resp) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedResp: got resp at cycle %0d, required none", cyc);
        end else begin
          monE = expQ.pop_front();
          checkOutput("respCycle", 128'(cyc), 128'(monE.respCyc));
          if (monE.isWrite) model[monE.line] = monE.data;
          else checkOutput("rdata", rdata, model[monE.line]);
        end
      end
    end
  end

  initial begin
    int           c1;
    int           c2;
    bit           atResp;
    bit           isWr;
    logic [15:0]  rAddr;
    logic [127:0] rData;

    rst = 1'b1;
    idleBus();
    address = '0;
    wdata   = '0;
    expErr  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetResp", resp, 1'b0);
    checkOutput("resetRdata", rdata, 128'h0);
    checkOutput("resetProtoErr", protoErr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    doOp(1'b0, 1'b1, 16'h0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    doOp(1'b1, 1'b0, 16'h0040, 128'h0);
    checkOutput("readLine4", rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    doOp(1'b1, 1'b0, 16'h0044, 128'h0);
    doOp(1'b1, 1'b0, 16'h0140, 128'h0);
    checkOutput("aliasLine4", rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    applyStimulus(1'b0, 1'b1, 16'h0070, 128'h7777_0000_1111_2222_3333_4444_5555_6666, 0);
    waitResp(c1);
    applyStimulus(1'b1, 1'b0, 16'h0070, 128'h0, 1);
    waitResp(c2);
    idleBus();
    checkOutput("b2bGap", 128'(c2 - c1), 128'(LAT + 1));
    checkOutput("b2bData", rdata, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
    @(negedge clk);
    checkOutput("protoErrClean", protoErr, 1'b0);

    atResp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      isWr  = 1'($urandom_range(0, 1));
      rAddr = 16'($urandom);
      rData = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(!isWr, isWr, rAddr, rData, atResp ? 1 : 0);
      waitResp(c1);
      if ($urandom_range(0, 1) == 1) begin
        atResp = 1'b1;
      end else begin
        idleBus();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        atResp = 1'b0;
      end
    end
    idleBus();
    @(negedge clk);
    checkOutput("protoErrRandom", protoErr, expErr);

    doOp(1'b1, 1'b1, 16'h0080, {16{8'hAA}});
    checkOutput("protoErrBoth", protoErr, 1'b1);
    doOp(1'b1, 1'b0, 16'h0080, 128'h0);
    checkOutput("bothWriteWon", rdata, {16{8'hAA}});
    checkOutput("protoErrSticky", protoErr, 1'b1);

    pulseReset();
    applyStimulus(1'b1, 1'b0, 16'h0090, 128'h0, 0);
    repeat (3) @(negedge clk);
    checkOutput("protoErrBeforeDrop", protoErr, 1'b0);
    @(negedge clk);
    read   = 1'b0;
    expErr = 1'b1;
    waitResp(c1);
    checkOutput("protoErrDrop", protoErr, 1'b1);
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 16'h0030, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstResp", resp, 1'b0);
    expQ.delete();
    expErr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idleBus();
    @(negedge clk);
    doOp(1'b1, 1'b0, 16'h0030, 128'h0);

    applyStimulus(1'b0, 1'b1, 16'h0030, 128'hCAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE, 0);
    repeat (LAT - 1) @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("respBeforeRst", resp, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("respAsyncDrop", resp, 1'b0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    idleBus();
    @(negedge clk);
    doOp(1'b1, 1'b0, 16'h0030, 128'h0);

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 128'(expQ.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
